keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner with debounce, key-code encoding and a small output FIFO, for ROWS×COLS keypads. It drives one column at a time and samples the row lines through a synchroniser. Each debounced key press produces exactly one code. Codes are delivered to the host through a valid/ready handshake.

## Interface
- ROWS, 4, number of row inputs (≥1)
- COLS, 4, number of column drives (≥2)
- SETTLE, 3, clocks a column is driven before row is sampled (≥3; covers 2-flop sync + line settle)
- DEBOUNCE, 4, consecutive stable clocks required for press and for release (≥1)
- FIFO_DEPTH, 4, key-code FIFO entries (power of two, ≥2)
- CODE_W (localparam), max(1, clog2(ROWS*COLS))
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- row  in  ROWS  asynchronous row sense, 1 = key closed in the driven column
- col  out  COLS  one-hot active-high column drive
- key_code  out  CODE_W  head-of-FIFO code = row_index*COLS + col_index
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  host accepts key_code when key_valid && key_ready
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  one-cycle pulse when a debounced key is dropped because the FIFO is full

## Operation
- One clock and one reset: clock, asynchronous active-high reset.
- row passes through a 2-flop synchroniser (rs). All decisions use rs.
- Scan FSM states: SCAN, PRESS, HELD, RELEASE.
- SCAN: col = one-hot(c). Dwell counter runs 0..SETTLE. At dwell==SETTLE, rs is sampled.
  - If rs==0: c advances (COLS-1 wraps to 0) and the dwell counter clears.
  - If rs!=0: latch r = lowest set index of rs, set deb=1 and go to PRESS. c is held.
- PRESS: the lowest set index of rs is checked each clock.
  - If it equals r: deb++.
  - Otherwise (including rs==0): return to SCAN with c advanced.
  - When deb reaches DEBOUNCE: push r*COLS+c and go to HELD.
- HELD: c is held. When rs==0, set deb=1 and go to RELEASE.
- RELEASE: if rs!=0, return to HELD. If rs==0, deb++. When deb reaches DEBOUNCE, go to SCAN with c advanced.
- Only the lowest-index row in the driven column is reported. Other columns are not scanned while a key is HELD (no rollover).
- A held key yields exactly one code regardless of hold time.
- FIFO is first-word-fall-through.
  - Pop: key_valid && key_ready.
  - Push when full and no pop in the same cycle: code dropped, overflow pulses 1 cycle, FIFO unchanged.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Pop when empty: impossible (key_valid=0).
- Arithmetic: code computed in CODE_W bits. Non-power-of-two ROWS*COLS leaves codes ≥ROWS*COLS unused. fifo pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - col = one-hot(0) (…0001)
  - key_valid=0, key_code=0, fifo_count=0, overflow=0
  - state SCAN, c=0, dwell=0, synchroniser cleared
- Reset asserted mid-operation: pending press and FIFO contents are lost. Outputs return to reset values immediately (asynchronous).
- Idle scan: each column is driven SETTLE+1 clocks. A full sweep takes COLS*(SETTLE+1) clocks.
- Press latency: key closed before col switches to c and held. The push occurs SETTLE+DEBOUNCE-1 clocks after the col switch. key_valid/key_code update the clock after the push (SETTLE+DEBOUNCE after the switch) if the FIFO was empty.
- All outputs are registered. key_code is stable while key_valid && !key_ready.
- fifo_count updates the clock after push/pop.
- overflow is high for the clock following the dropped push.

## Test plan
All scenarios use defaults (ROWS=4, COLS=4, SETTLE=3, DEBOUNCE=4, FIFO_DEPTH=4) unless stated.
- Reset and idle: reset pulse, row=0.
  - col=0001 and key_valid=0 during reset.
  - col sequence then 0001→0010→0100→1000→0001, 4 clocks each.
- Single press: row[2] high while col[1] driven, held 100 clocks, key_ready=0.
  - key_valid rises 7 clocks after col=0010; key_code=9; fifo_count=1.
  - No second code while held.
  - After release, col=0100 appears 4 clocks after rs goes to 0.
- Bounce: row[0] toggles every 2 clocks for 40 clocks, then stays 0.
  - No push; key_valid=0; scan keeps rotating.
- Overflow: key_ready=0, five distinct presses with codes 0, 5, 10, 15, 3.
  - fifo_count=4; overflow pulses once on the 5th press.
  - Then key_ready=1 pops 0, 5, 10, 15 in order; key_valid falls after the 4th pop.
- Full push+pop: FIFO full; key_ready=1 held in the cycle a new code pushes.
  - fifo_count stays 4; overflow=0; the new code appears last.
- Reset mid-debounce plus odd geometry: ROWS=3, COLS=5, CODE_W=4.
  - Press row[2] col[4] → key_code=14.
  - Second press with reset asserted during PRESS: no code emitted; col=00001 immediately.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Matrix keypad scanner for ROWS x COLS keypads. One column is driven at a
//   time and the row lines are sampled through a 2-flop synchroniser. Each
//   debounced press yields exactly one code (row*COLS + col). Codes go into a
//   small first-word-fall-through FIFO that the host drains with valid/ready.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high; clears all state
//   row         asynchronous row sense, 1 = key closed in the driven column
//   col         one-hot active-high column drive (registered)
//   key_code    head-of-FIFO code
//   key_valid   FIFO non-empty
//   key_ready   host accepts key_code when key_valid && key_ready
//   fifo_count  occupied FIFO entries
//   overflow    one-cycle pulse when a debounced code is dropped (FIFO full)
module keypad_scanner #(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int SETTLE     = 3,
  parameter  int DEBOUNCE   = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int CODE_W     = ($clog2(ROWS*COLS) > 0) ? $clog2(ROWS*COLS) : 1,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SETTLE + 1);
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {SCAN, PRESS, HELD, RELEASE} state_t;

  // ---------------------------------------------------------------------
  // Row synchroniser: sync_pipe[1] is the only row view used by the FSM.
  // ---------------------------------------------------------------------
  logic [1:0][ROWS-1:0] sync_pipe;
  logic [ROWS-1:0]      rs;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[0], row};
  end

  assign rs = sync_pipe[1];

  // Lowest set row index; scanning downward lets the lowest index win.
  logic [RW-1:0] low_idx;
  logic          low_any;

  always_comb begin
    low_idx = '0;
    low_any = |rs;
    for (int i = ROWS - 1; i >= 0; i--)
      if (rs[i]) low_idx = RW'(i);
  end

  // ---------------------------------------------------------------------
  // Scan / debounce FSM
  // ---------------------------------------------------------------------
  state_t          state, state_n;
  logic [CW-1:0]   c, c_n, c_adv;
  logic [DW-1:0]   dwell, dwell_n;
  logic [RW-1:0]   r, r_n;
  logic [BW-1:0]   deb, deb_n;
  logic [COLS-1:0] col_n;
  logic            push;
  logic [CODE_W-1:0] push_code;

  assign c_adv     = (c == CW'(COLS - 1)) ? '0 : c + 1'b1;
  assign push_code = CODE_W'(r) * CODE_W'(COLS) + CODE_W'(c);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SCAN;
      c     <= '0;
      dwell <= '0;
      r     <= '0;
      deb   <= '0;
      col   <= COLS'(1);
    end else begin
      state <= state_n;
      c     <= c_n;
      dwell <= dwell_n;
      r     <= r_n;
      deb   <= deb_n;
      col   <= col_n;
    end
  end

  // deb counts the stable cycle being evaluated, so the threshold fires on
  // the cycle where the count would reach DEBOUNCE, not one cycle later.
  always_comb begin
    state_n = state;
    c_n     = c;
    dwell_n = dwell;
    r_n     = r;
    deb_n   = deb;
    push    = 1'b0;
    unique case (state)
      SCAN: begin
        if (dwell == DW'(SETTLE)) begin
          dwell_n = '0;
          if (!low_any) begin
            c_n = c_adv;
          end else begin
            r_n     = low_idx;
            deb_n   = BW'(1);
            state_n = PRESS;
          end
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end
      PRESS: begin
        if (low_any && low_idx == r) begin
          if (deb >= BW'(DEBOUNCE - 1)) begin
            push    = 1'b1;
            state_n = HELD;
          end else begin
            deb_n = deb + 1'b1;
          end
        end else begin
          state_n = SCAN;
          c_n     = c_adv;
          dwell_n = '0;
        end
      end
      HELD: begin
        if (!low_any) begin
          deb_n   = BW'(1);
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (low_any) begin
          state_n = HELD;
        end else if (deb >= BW'(DEBOUNCE - 1)) begin
          state_n = SCAN;
          c_n     = c_adv;
          dwell_n = '0;
        end else begin
          deb_n = deb + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
    col_n = COLS'(1) << c_n;
  end

  // ---------------------------------------------------------------------
  // Key-code FIFO (first-word-fall-through). A push into a full FIFO is
  // still accepted when the host pops in the same cycle.
  // ---------------------------------------------------------------------
  logic [FIFO_DEPTH-1:0][CODE_W-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop, full, do_push;

  assign pop     = key_valid && key_ready;
  assign full    = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign do_push = push && (!full || pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (do_push) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign key_valid = (fifo_count != '0);
  assign key_code  = mem[rd_ptr];

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: default 4x4 geometry (dut_a) plus a 3x5
// instance (dut_b) for the odd-geometry / mid-press reset case. A keypad
// model drives row from col and a press map; expected codes go into a
// scoreboard queue at press time and are popped when the DUT hands them out.
module tb_keypad_scanner;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // ---- DUT A: 4x4 defaults ----
  logic       reset, key_ready, key_valid, overflow;
  logic [3:0] row, col, key_code;
  logic [2:0] fifo_count;

  keypad_scanner dut_a (
    .clock(clock), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  // ---- DUT B: 3 rows x 5 cols ----
  logic       reset2, key_ready2, key_valid2, overflow2;
  logic [2:0] row2, fifo_count2;
  logic [4:0] col2;
  logic [3:0] key_code2;

  keypad_scanner #(.ROWS(3), .COLS(5)) dut_b (
    .clock(clock), .reset(reset2), .row(row2), .col(col2),
    .key_code(key_code2), .key_valid(key_valid2), .key_ready(key_ready2),
    .fifo_count(fifo_count2), .overflow(overflow2)
  );

  // ---- keypad models ----
  logic [3:0][3:0] pressed;   // [row][col]
  logic [2:0][4:0] pressed2;
  logic            bounce_en, bounce_val;

  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && col[c]) row[r] = 1'b1;
    if (bounce_en) row[0] = bounce_val;
  end

  always_comb begin
    row2 = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        if (pressed2[r][c] && col2[c]) row2[r] = 1'b1;
  end

  // Cycles with overflow high on dut_a.
  int ov_cnt = 0;
  always @(negedge clock) if (overflow === 1'b1) ov_cnt++;

  int n_cmp = 0, n_bad = 0;
  logic [3:0] sb[$];
  logic [3:0] sb2[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] target, output int n);
    n = 0;
    while (col !== target && n < 200) begin tick(); n++; end
    if (col !== target) check("wait_col_timeout", col, target);
  endtask

  task automatic wait_col2(input logic [4:0] target, output int n);
    n = 0;
    while (col2 !== target && n < 200) begin tick(); n++; end
    if (col2 !== target) check("wait_col2_timeout", col2, target);
  endtask

  task automatic until_col_change(output int n);
    logic [3:0] cur;
    cur = col;
    n = 0;
    while (col === cur && n < 200) begin tick(); n++; end
  endtask

  task automatic drain_one(input string tag);
    logic [3:0] exp;
    check({tag, "_valid"}, key_valid, 1);
    if (sb.size() > 0) exp = sb.pop_front();
    else begin
      exp = 4'hx;
      check({tag, "_sb_empty"}, sb.size(), 1);
    end
    check({tag, "_code"}, key_code, exp);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
  endtask

  // Close key (r,c) while another column is driven, hold it well past the
  // debounce window, release, and expect the scan to move on 6 cycles later
  // (2 sync + 4 release-debounce).
  task automatic press_key(input int r, input int c, input bit expect_code);
    int n;
    wait_col(4'(1 << ((c + 1) % 4)), n);
    pressed[r][c] = 1'b1;
    if (expect_code) sb.push_back(4'(r * 4 + c));
    wait_col(4'(1 << c), n);
    repeat (12) tick();
    pressed[r][c] = 1'b0;
    until_col_change(n);
    check("press_release_delay", n, 6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] exp;
    logic [3:0] exp_seq[3] = '{4'b0100, 4'b1000, 4'b0001};

    reset = 1'b1; reset2 = 1'b1;
    key_ready = 1'b0; key_ready2 = 1'b0;
    pressed = '0; pressed2 = '0;
    bounce_en = 1'b0; bounce_val = 1'b0;
    repeat (3) tick();

    // ---- reset values ----
    check("rst_col", col, 4'b0001);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_col2", col2, 5'b00001);
    check("rst_valid2", key_valid2, 0);

    // ---- idle scan: 4 clocks per column ----
    reset = 1'b0;
    wait_col(4'b0010, n);
    check("idle_first_dwell", n, 4);
    for (int k = 0; k < 3; k++) begin
      until_col_change(n);
      check("idle_dwell", n, 4);
      check("idle_col", col, exp_seq[k]);
    end

    // ---- single press: row 2, col 1 -> code 9 ----
    wait_col(4'b0100, n);
    pressed[2][1] = 1'b1;
    sb.push_back(4'd9);
    wait_col(4'b0010, n);
    n = 0;
    while (key_valid !== 1'b1 && n < 50) begin tick(); n++; end
    check("press_latency", n, 7);
    check("press_code", key_code, sb[0]);
    check("press_count", fifo_count, 1);
    repeat (100) tick();
    check("held_count", fifo_count, 1);
    check("held_col", col, 4'b0010);
    pressed[2][1] = 1'b0;
    until_col_change(n);
    check("release_delay", n, 6);
    check("release_col", col, 4'b0100);
    drain_one("single");
    check("single_empty", key_valid, 0);

    // ---- bounce on row 0: no code ----
    bounce_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bounce_val = ((i / 2) % 2) == 0;
      tick();
    end
    bounce_val = 1'b0;
    bounce_en  = 1'b0;
    repeat (10) tick();
    check("bounce_valid", key_valid, 0);
    check("bounce_count", fifo_count, 0);
    check("bounce_ovf_cnt", ov_cnt, 0);
    until_col_change(n);
    until_col_change(n);
    check("bounce_rotate", n, 4);

    // ---- overflow: 5 presses into a 4-entry FIFO ----
    press_key(0, 0, 1);
    press_key(1, 1, 1);
    press_key(2, 2, 1);
    press_key(3, 3, 1);
    check("ovf_full_count", fifo_count, 4);
    check("ovf_none_yet", ov_cnt, 0);
    press_key(0, 3, 0);
    check("ovf_count_after", fifo_count, 4);
    check("ovf_pulses", ov_cnt, 1);
    for (int k = 0; k < 4; k++) drain_one("ovf_drain");
    check("ovf_drained", key_valid, 0);
    check("ovf_drained_count", fifo_count, 0);

    // ---- full FIFO, push and pop in the same cycle ----
    press_key(0, 1, 1);
    press_key(0, 2, 1);
    press_key(1, 0, 1);
    press_key(2, 0, 1);
    check("pp_full", fifo_count, 4);
    wait_col(4'b1000, n);
    pressed[1][2] = 1'b1;
    sb.push_back(4'd6);
    wait_col(4'b0100, n);
    repeat (6) tick();   // push-decision cycle
    check("pp_pre_count", fifo_count, 4);
    exp = sb.pop_front();
    check("pp_head", key_code, exp);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("pp_count", fifo_count, 4);
    check("pp_ovf", overflow, 0);
    check("pp_ovf_cnt", ov_cnt, 1);
    pressed[1][2] = 1'b0;
    until_col_change(n);
    for (int k = 0; k < 4; k++) drain_one("pp_drain");
    check("pp_empty", key_valid, 0);

    // ---- odd geometry 3x5: row 2, col 4 -> code 14 ----
    reset2 = 1'b0;
    pressed2[2][4] = 1'b1;
    sb2.push_back(4'd14);
    wait_col2(5'b10000, n);
    check("g2_sweep", n, 16);
    n = 0;
    while (key_valid2 !== 1'b1 && n < 50) begin tick(); n++; end
    check("g2_latency", n, 7);
    exp = (sb2.size() > 0) ? sb2.pop_front() : 4'hx;
    check("g2_code", key_code2, exp);
    check("g2_count", fifo_count2, 1);
    pressed2[2][4] = 1'b0;
    key_ready2 = 1'b1;
    tick();
    key_ready2 = 1'b0;
    check("g2_popped", key_valid2, 0);

    // second press, reset lands in PRESS
    wait_col2(5'b00010, n);
    pressed2[1][2] = 1'b1;
    wait_col2(5'b00100, n);
    repeat (5) tick();
    reset2 = 1'b1;
    #1;
    check("g2_rst_col", col2, 5'b00001);
    check("g2_rst_valid", key_valid2, 0);
    check("g2_rst_count", fifo_count2, 0);
    check("g2_rst_code", key_code2, 0);
    pressed2[1][2] = 1'b0;
    tick(); tick();
    reset2 = 1'b0;
    repeat (60) tick();
    check("g2_no_code", key_valid2, 0);
    check("g2_no_count", fifo_count2, 0);
    check("g2_ovf", overflow2, 0);
    check("g2_sb_left", sb2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
